// File: rtl/compressor7_2_pipe.sv
// Pipelined 7-row to sum/carry reduction with an optional approximate cell on the low columns.
// The exact row sum is formed alongside so the delivered error travels with each result.
module compressor7_2_pipe #(
  parameter int W       = 8,
  parameter int STAGES  = 2,
  parameter int APX_LSB = 4,
  parameter int CW      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7*W-1:0] rows_i,
  input  logic           mode_i,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W+2:0]   sum_o,
  output logic [W+2:0]   carry_o,
  output logic [W+2:0]   err_o,
  output logic [CW-1:0]  err_cnt,
  input  logic           clr_cnt
);
  localparam int OW = W + 3;

  typedef struct packed {
    logic [OW-1:0] sum;
    logic [OW-1:0] carry;
    logic [OW-1:0] err;
  } res_t;

  function automatic void csa(input logic [OW-1:0] a, b, c,
                              output logic [OW-1:0] s, cy);
    s  = a ^ b ^ c;
    cy = ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  logic [6:0][W-1:0]  row;
  logic [6:0][OW-1:0] mrow;
  logic [W-1:0]       lowm;
  logic [OW-1:0]      sv, cv, e, a;
  logic [2:0]         p;
  logic [OW-1:0]      s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6;
  res_t               res_in;

  assign row = rows_i;

  // Approximated columns are stripped from every row and replaced by the
  // parity bit (sv) and the >=2 threshold bit one column up (cv).
  always_comb begin
    lowm = '0;
    sv   = '0;
    cv   = '0;
    e    = '0;
    a    = '0;
    p    = '0;
    for (int i = 0; i < W; i++) begin
      lowm[i] = mode_i && (i < APX_LSB);
      p = '0;
      for (int r = 0; r < 7; r++) p = p + 3'(row[r][i]);
      if (lowm[i]) begin
        sv[i]   = p[0];
        cv[i+1] = (p >= 3'd2);
      end
    end
    for (int r = 0; r < 7; r++) begin
      mrow[r] = OW'(row[r] & ~lowm);
      e = e + OW'(row[r]);
      a = a + mrow[r];
    end
    a = a + sv + cv;
  end

  // 9 -> 6 -> 4 -> 3 -> 2 carry-save tree
  always_comb begin
    csa(mrow[0], mrow[1], mrow[2], s0, c0);
    csa(mrow[3], mrow[4], mrow[5], s1, c1);
    csa(mrow[6], sv,      cv,      s2, c2);
    csa(s0, c0, s1, s3, c3);
    csa(c1, s2, c2, s4, c4);
    csa(s3, c3, s4, s5, c5);
    csa(s5, c5, c4, s6, c6);
    res_in.sum   = s6;
    res_in.carry = c6;
    res_in.err   = e - a;
  end

  logic              advance;
  logic [STAGES:0]   vld_pipe;
  logic [STAGES-1:0] vld_q;
  res_t              res_q [STAGES];

  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  assign vld_pipe  = {vld_q, in_valid & advance};
  assign out_valid = vld_pipe[STAGES];
  assign sum_o     = res_q[STAGES-1].sum;
  assign carry_o   = res_q[STAGES-1].carry;
  assign err_o     = res_q[STAGES-1].err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) res_q[k] <= '0;
    end else if (advance) begin
      vld_q    <= vld_pipe[STAGES-1:0];
      res_q[0] <= res_in;
      for (int k = 1; k < STAGES; k++) res_q[k] <= res_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (clr_cnt)
      err_cnt <= '0;
    else if (out_valid && out_ready && (err_o != '0) && (err_cnt != {CW{1'b1}}))
      err_cnt <= err_cnt + CW'(1);
  end
endmodule

// File: tb/tb_compressor7_2_pipe.sv
// Scoreboard bench for compressor7_2_pipe: reference row-sum model, stall, counter and reset scenarios.
module tb_compressor7_2_pipe;
  localparam int W = 8, STAGES = 2, L = 4, CW = 4, OW = 11;

  logic          clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, mode_i = 0, clr_cnt = 0;
  logic [7*W-1:0] rows_i = '0;
  logic          in_ready, out_valid;
  logic [OW-1:0] sum_o, carry_o, err_o;
  logic [CW-1:0] err_cnt;

  compressor7_2_pipe #(.W(W), .STAGES(STAGES), .APX_LSB(L), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rows_i(rows_i), .mode_i(mode_i), .out_valid(out_valid), .out_ready(out_ready),
    .sum_o(sum_o), .carry_o(carry_o), .err_o(err_o), .err_cnt(err_cnt), .clr_cnt(clr_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] val;
    logic [OW-1:0] err;
  } exp_t;

  exp_t         sbq[$];
  int           nassert = 0, nfail = 0;
  logic [CW-1:0] exp_cnt = '0;
  exp_t         mon_x;
  logic [OW-1:0] mon_got;

  localparam logic [55:0] ALLFF = {7{8'hFF}};

  function automatic exp_t model(input logic [55:0] r, input logic m);
    logic [OW-1:0] e, a;
    logic [7:0] rw;
    int p;
    exp_t x;
    e = '0; a = '0;
    for (int k = 0; k < 7; k++) begin
      rw = r[k*8 +: 8];
      e  = e + OW'(rw);
      a  = a + OW'((rw >> L) << L);
    end
    for (int i = 0; i < L; i++) begin
      p = 0;
      for (int k = 0; k < 7; k++) p = p + int'(r[k*8+i]);
      a = a + (OW'(p & 1) << i) + (OW'(p >= 2 ? 1 : 0) << (i + 1));
    end
    x.val = m ? a : e;
    x.err = m ? e - a : '0;
    return x;
  endfunction

  // Scoreboard and counter model, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_cnt = '0;
    end else begin
      nassert++;
      if (err_cnt !== exp_cnt) begin
        nfail++;
        $display("FAIL err_cnt_track: got %0d expected %0d at %0t", err_cnt, exp_cnt, $time);
      end
      mon_x.err = '0;
      if (out_valid && out_ready) begin
        nassert++;
        if (sbq.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_output: got out_valid=1 expected no result at %0t", $time);
        end else begin
          mon_x   = sbq.pop_front();
          mon_got = sum_o + carry_o;
          nassert++;
          if (mon_got !== mon_x.val) begin
            nfail++;
            $display("FAIL result_value: got %0d expected %0d at %0t", mon_got, mon_x.val, $time);
          end
          nassert++;
          if (err_o !== mon_x.err) begin
            nfail++;
            $display("FAIL result_err: got %0d expected %0d at %0t", err_o, mon_x.err, $time);
          end
        end
      end
      if (clr_cnt) exp_cnt = '0;
      else if (out_valid && out_ready && mon_x.err != '0 && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    end
  end

  task automatic send(input logic [55:0] r, input logic m);
    bit acc;
    int n;
    acc = 0; n = 0;
    in_valid = 1; rows_i = r; mode_i = m;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sbq.push_back(model(r, m));
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      nassert++; nfail++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    nassert++;
    if (sbq.size() != 0) begin
      nfail++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", sbq.size());
    end
  endtask

  task automatic test_reset();
    #2;
    nassert++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL reset_handshake: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    nassert++;
    if (sum_o !== '0 || carry_o !== '0 || err_o !== '0 || err_cnt !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: got sum=%0h carry=%0h err=%0h cnt=%0d expected all 0",
               sum_o, carry_o, err_o, err_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single(input logic [55:0] r, input logic m, input logic [OW-1:0] ev,
                             input logic [OW-1:0] ee, input logic [CW-1:0] ecnt);
    logic [OW-1:0] got;
    send(r, m);
    @(negedge clk);
    nassert++;
    if (out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL latency_early: got out_valid=%b expected 0 one cycle after transfer", out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    got = sum_o + carry_o;
    nassert++;
    if (out_valid !== 1'b1) begin
      nfail++;
      $display("FAIL latency: got out_valid=%b expected 1 two cycles after transfer", out_valid);
    end
    nassert++;
    if (got !== ev || err_o !== ee) begin
      nfail++;
      $display("FAIL single_value: got sum+carry=%0d err=%0d expected %0d/%0d", got, err_o, ev, ee);
    end
    @(posedge clk); #1;
    nassert++;
    if (err_cnt !== ecnt) begin
      nfail++;
      $display("FAIL single_cnt: got %0d expected %0d", err_cnt, ecnt);
    end
  endtask

  task automatic test_back_to_back();
    fork
      begin
        logic [55:0] r;
        for (int k = 0; k < 10; k++) begin
          r = 56'({$urandom(), $urandom()});
          send(r, k[0]);
        end
      end
      begin
        logic [OW-1:0] hs, hc, he;
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          nassert++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            nfail++;
            $display("FAIL stall_ready: got in_ready=%b out_valid=%b expected 0/1", in_ready, out_valid);
          end
          if (k == 0) begin
            hs = sum_o; hc = carry_o; he = err_o;
          end else begin
            nassert++;
            if (sum_o !== hs || carry_o !== hc || err_o !== he) begin
              nfail++;
              $display("FAIL stall_hold: got %0h/%0h/%0h expected %0h/%0h/%0h",
                       sum_o, carry_o, err_o, hs, hc, he);
            end
          end
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
  endtask

  task automatic test_saturate();
    repeat (20) send(ALLFF, 1'b1);
    drain();
    nassert++;
    if (err_cnt !== 4'd15) begin
      nfail++;
      $display("FAIL saturate: got %0d expected 15", err_cnt);
    end
  endtask

  task automatic test_clear();
    out_ready = 0;
    send(ALLFF, 1'b1);
    @(posedge clk); #1;
    nassert++;
    if (out_valid !== 1'b1 || err_cnt !== 4'd15) begin
      nfail++;
      $display("FAIL clear_setup: got out_valid=%b cnt=%0d expected 1/15", out_valid, err_cnt);
    end
    clr_cnt = 1; out_ready = 1;
    @(posedge clk); #1;
    clr_cnt = 0;
    nassert++;
    if (err_cnt !== '0) begin
      nfail++;
      $display("FAIL clear_wins: got %0d expected 0", err_cnt);
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    logic [55:0] r;
    out_ready = 0;
    r = 56'({$urandom(), $urandom()});
    send(r, 1'b0);
    send(ALLFF, 1'b1);
    nassert++;
    if (out_valid !== 1'b1) begin
      nfail++;
      $display("FAIL inflight_setup: got out_valid=%b expected 1", out_valid);
    end
    #2 rst_n = 0;
    #1;
    nassert++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== '0) begin
      nfail++;
      $display("FAIL async_reset: got out_valid=%b in_ready=%b cnt=%0d expected 0/1/0",
               out_valid, in_ready, err_cnt);
    end
    sbq.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1; out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nassert++;
      if (out_valid !== 1'b0) begin
        nfail++;
        $display("FAIL stale_result: got out_valid=%b expected 0 after reset", out_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single(ALLFF, 1'b0, 11'd1785, 11'd0, 4'd0);
    test_single(ALLFF, 1'b1, 11'd1725, 11'd60, 4'd1);
    test_single(56'h0101, 1'b1, 11'd2, 11'd0, 4'd1);
    test_back_to_back();
    test_saturate();
    test_clear();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
